// File: rtl/adc_spi_capture.sv
// ==== adc_spi_capture: drives a 12-bit AD7476-class serial ADC, returns parallel sample ====
// Revision 1.0 - initial release
`default_nettype none

module adc_spi_capture #(
  parameter int CLK_DIV      = 4,
  parameter int QUIET_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        sdata,
  output logic        sclk,
  output logic        cs_n,
  output logic [11:0] data,
  output logic        done,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_QUIET = 3'd4
  } state_t;

  localparam logic [8:0] C_HALF_LAST  = 9'(CLK_DIV - 1);
  localparam logic [8:0] C_FULL_LAST  = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] C_QUIET_LAST = 9'(QUIET_CYCLES - 1);

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic        pending_q, pending_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic [11:0] data_q, data_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    pending_d   = pending_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    data_d      = data_q;
    done_d      = 1'b0;
    frame_err_d = frame_err_q;

    case (state_q)
      S_IDLE: begin
        if (start || pending_q) begin
          state_d   = S_SETUP;
          cs_n_d    = 1'b0;
          sclk_d    = 1'b1;
          cnt_d     = 9'd0;
          pending_d = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_q == C_HALF_LAST) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b0;
          cnt_d   = 9'd0;
          bit_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_SHIFT: begin
        // bit_q reaches 16 on the last rising edge; leave after that single high cycle
        if (cnt_q == C_HALF_LAST) begin
          sclk_d  = 1'b1;
          shift_d = {shift_q[14:0], sdata};
          bit_d   = bit_q + 5'd1;
          cnt_d   = cnt_q + 9'd1;
        end else if (bit_q == 5'd16) begin
          state_d     = S_DONE;
          cs_n_d      = 1'b1;
          sclk_d      = 1'b1;
          done_d      = 1'b1;
          data_d      = shift_q[11:0];
          frame_err_d = |shift_q[15:12];
        end else if (cnt_q == C_FULL_LAST) begin
          sclk_d = 1'b0;
          cnt_d  = 9'd0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_DONE: begin
        state_d = S_QUIET;
        cnt_d   = 9'd0;
        if (start) pending_d = 1'b1;
      end
      S_QUIET: begin
        if (start) pending_d = 1'b1;
        if (cnt_q == C_QUIET_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 9'd0;
      bit_q       <= 5'd0;
      shift_q     <= 16'd0;
      pending_q   <= 1'b0;
      sclk_q      <= 1'b1;
      cs_n_q      <= 1'b1;
      data_q      <= 12'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      pending_q   <= pending_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      data_q      <= data_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign data      = data_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

`default_nettype wire
